// File: rtl/dsp_seq_pkg.sv
// ============================================================================
// Module      : dsp_seq_pkg
// Description : Shared constants and state encoding for the DSP48A1
//               dot-product sequencer. It provides the OPMODE codes issued
//               to the slice and the sequencer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_seq_pkg;

    // OPMODE codes. Bits [7:4] are always 0: post-adder adds, no pre-adder
    // and CIN=0.
    localparam logic [7:0] OPM_IDLE  = 8'h00;        // X=0, Z=0
    localparam logic [7:0] OPM_CLEAR = 8'b0000_0001; // X=M, Z=0 : restart sum
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001; // X=M, Z=P : accumulate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : dsp_seq_pkg

`default_nettype wire

// File: rtl/dsp_seq_pipe.sv
// ============================================================================
// Module      : dsp_seq_pipe
// Description : Fixed-depth shift register with asynchronous active-low reset.
//               It delays OPMODE codes and slot-landing tags so they stay
//               aligned with the DSP slice's internal registers.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset (clears every stage)
//               d_i   - WIDTH-bit input
//               q_o   - d_i delayed by DEPTH cycles (DEPTH=0 is a wire)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_seq_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule : dsp_seq_pipe

`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
// ============================================================================
// Module      : dsp_mac_sequencer
// Description : Drives a DSP48A1 slice as a dot-product engine. It accepts a
//               length-N command, streams N (A,B) pairs into the slice with
//               a per-slot OPMODE, waits out the slice pipeline, then
//               captures P and returns it on a valid/ready result port.
// Ports       : clk, rst_n              - clock, async active-low reset
//               cmd_valid_i/cmd_ready_o - command handshake, cmd_len_i = N
//               s_valid_i/s_ready_o     - operand handshake, s_a_i/s_b_i
//               dsp_a_o/dsp_b_o         - slice A/B operands
//               dsp_opmode_o, dsp_ce_o  - slice OPMODE and common CE
//               dsp_p_i, dsp_carryout_i - slice P and CARRYOUT
//               res_valid_o/res_ready_i - result handshake
//               res_data_o, res_ovf_o   - sum and sticky carry flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W    = 16,
    parameter int OPM_SKEW = 1,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [17:0]      s_a_i,
    input  logic [17:0]      s_b_i,
    output logic [17:0]      dsp_a_o,
    output logic [17:0]      dsp_b_o,
    output logic [7:0]       dsp_opmode_o,
    output logic             dsp_ce_o,
    input  logic [47:0]      dsp_p_i,
    input  logic             dsp_carryout_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [47:0]      res_data_o,
    output logic             res_ovf_o
);

    localparam int              DRAIN_CYC  = OPM_SKEW + PIPE_LAT;
    localparam int              DCNT_W     = $clog2(DRAIN_CYC + 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [DCNT_W-1:0]  drain_q, drain_d;
    logic               seen_first_q, seen_first_d;
    logic [17:0]        dsp_a_q, dsp_a_d;
    logic [17:0]        dsp_b_q, dsp_b_d;
    logic [7:0]         opm_pre_q, opm_pre_d;   // OPMODE of the slot on A/B now
    logic               land_pre_q, land_pre_d; // slot on A/B now counts for OVF
    logic [47:0]        res_data_q, res_data_d;
    logic               res_ovf_q, res_ovf_d;

    logic               w_s_fire;
    logic               w_land_now;
    logic               w_slice_active;

    assign w_s_fire       = s_valid_i && (state_q == ST_STREAM);
    assign w_slice_active = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

    // OPMODE follows its A/B slot by OPM_SKEW cycles.
    dsp_seq_pipe #(
        .WIDTH (8),
        .DEPTH (OPM_SKEW)
    ) u_opm_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (opm_pre_q),
        .q_o   (dsp_opmode_o)
    );

    // A tagged slot reaches P (and CARRYOUT) PIPE_LAT cycles after its A/B.
    dsp_seq_pipe #(
        .WIDTH (1),
        .DEPTH (PIPE_LAT)
    ) u_land_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (land_pre_q),
        .q_o   (w_land_now)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            drain_q      <= '0;
            seen_first_q <= 1'b0;
            dsp_a_q      <= '0;
            dsp_b_q      <= '0;
            opm_pre_q    <= OPM_IDLE;
            land_pre_q   <= 1'b0;
            res_data_q   <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            drain_q      <= drain_d;
            seen_first_q <= seen_first_d;
            dsp_a_q      <= dsp_a_d;
            dsp_b_q      <= dsp_b_d;
            opm_pre_q    <= opm_pre_d;
            land_pre_q   <= land_pre_d;
            res_data_q   <= res_data_d;
            res_ovf_q    <= res_ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        drain_d      = drain_q;
        seen_first_d = seen_first_q;
        dsp_a_d      = '0;          // zero operands add nothing to P
        dsp_b_d      = '0;
        opm_pre_d    = OPM_IDLE;
        land_pre_d   = 1'b0;
        res_data_d   = res_data_q;
        res_ovf_d    = res_ovf_q;

        // Only landings while the slice is clocked belong to this command.
        if (w_land_now && w_slice_active) begin
            res_ovf_d = res_ovf_q | dsp_carryout_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    seen_first_d = 1'b0;
                    res_ovf_d    = 1'b0;
                    if (cmd_len_i != '0) begin
                        remain_d = cmd_len_i;
                        state_d  = ST_STREAM;
                    end else begin
                        res_data_d = '0;
                        state_d    = ST_DONE;
                    end
                end
            end

            ST_STREAM: begin
                if (w_s_fire) begin
                    dsp_a_d      = s_a_i;
                    dsp_b_d      = s_b_i;
                    opm_pre_d    = seen_first_q ? OPM_ACC : OPM_CLEAR;
                    land_pre_d   = 1'b1;
                    seen_first_d = 1'b1;
                    remain_d     = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        drain_d = DRAIN_LAST;
                        state_d = ST_DRAIN;
                    end
                end else if (seen_first_q) begin
                    // Bubble after the first pair: holds P, carry is sampled.
                    opm_pre_d  = OPM_ACC;
                    land_pre_d = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Drain bubbles land after capture, so they are not tagged.
                opm_pre_d = OPM_ACC;
                if (drain_q == '0) begin
                    res_data_d = dsp_p_i;
                    state_d    = ST_DONE;
                end else begin
                    drain_d = drain_q - DCNT_W'(1);
                end
            end

            ST_DONE: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign s_ready_o   = (state_q == ST_STREAM);
    assign dsp_ce_o    = w_slice_active;
    assign res_valid_o = (state_q == ST_DONE);
    assign dsp_a_o     = dsp_a_q;
    assign dsp_b_o     = dsp_b_q;
    assign res_data_o  = res_data_q;
    assign res_ovf_o   = res_ovf_q;

endmodule : dsp_mac_sequencer

`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
// ============================================================================
// Module      : tb_dsp_mac_sequencer
// Description : Self-checking bench for dsp_mac_sequencer. It contains a
//               behavioural DSP48A1 slice (A1REG/OPMODEREG/MREG/PREG, sync
//               resets tied off) plus a dot-product reference model, and
//               runs directed and randomized commands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_mac_sequencer;

    localparam int LEN_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [17:0]       s_a = '0;
    logic [17:0]       s_b = '0;
    logic [17:0]       dsp_a, dsp_b;
    logic [7:0]        dsp_opmode;
    logic              dsp_ce;
    logic [47:0]       dsp_p;
    logic              dsp_carryout;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [47:0]       res_data;
    logic              res_ovf;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .LEN_W    (LEN_W),
        .OPM_SKEW (1),
        .PIPE_LAT (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_len_i      (cmd_len),
        .s_valid_i      (s_valid),
        .s_ready_o      (s_ready),
        .s_a_i          (s_a),
        .s_b_i          (s_b),
        .dsp_a_o        (dsp_a),
        .dsp_b_o        (dsp_b),
        .dsp_opmode_o   (dsp_opmode),
        .dsp_ce_o       (dsp_ce),
        .dsp_p_i        (dsp_p),
        .dsp_carryout_i (dsp_carryout),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_data_o     (res_data),
        .res_ovf_o      (res_ovf)
    );

    // ---------------- behavioural DSP48A1 slice ----------------
    logic [17:0]        sl_a1 = '0, sl_b1 = '0;
    logic [7:0]         sl_opm = '0;
    logic signed [35:0] sl_m = '0;
    logic [47:0]        sl_p = '0;
    logic               sl_co = 1'b0;
    logic [47:0]        sl_x, sl_z;

    always_comb begin
        sl_x = (sl_opm[1:0] == 2'b01) ? {{12{sl_m[35]}}, sl_m} : 48'd0;
        sl_z = (sl_opm[3:2] == 2'b10) ? sl_p : 48'd0;
    end

    always @(posedge clk) begin
        if (dsp_ce) begin
            sl_a1           <= dsp_a;
            sl_b1           <= dsp_b;
            sl_opm          <= dsp_opmode;
            sl_m            <= $signed(sl_a1) * $signed(sl_b1);
            {sl_co, sl_p}   <= {1'b0, sl_z} + {1'b0, sl_x};
        end
    end

    assign dsp_p        = sl_p;
    assign dsp_carryout = sl_co;

    // ---------------- bookkeeping ----------------
    int          total = 0;
    int          bad = 0;
    int          n_results = 0;
    int          n_expected = 0;
    logic [47:0] exp_data_q [$];
    logic        exp_ovf_q  [$];
    logic [17:0] cur_a [$];
    logic [17:0] cur_b [$];
    logic [47:0] last_data = '0;
    logic        last_ovf = 1'b0;
    logic        hold_pend = 1'b0;
    logic [47:0] hold_data = '0;
    logic        hold_ovf = 1'b0;
    logic        ce_watch = 1'b0;
    logic        ce_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Dot product of cur_a/cur_b: 36-bit signed products, sum mod 2^48,
    // overflow = any carry out of the 48-bit add after the first pair.
    task automatic model(output logic [47:0] sum, output logic ovf);
        logic signed [47:0] sa, sb, pr;
        logic [48:0]        t;
        sum = '0;
        ovf = 1'b0;
        for (int i = 0; i < cur_a.size(); i++) begin
            sa = 48'($signed(cur_a[i]));
            sb = 48'($signed(cur_b[i]));
            pr = sa * sb;
            if (i == 0) begin
                sum = pr;
            end else begin
                t   = {1'b0, sum} + {1'b0, pr};
                sum = t[47:0];
                ovf = ovf | t[48];
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("opmode_upper_zero", 64'(dsp_opmode[7:4]), 64'd0);
            if (ce_watch && dsp_ce) ce_seen <= 1'b1;
            if (hold_pend) begin
                chk("hold_data", 64'(res_data), 64'(hold_data));
                chk("hold_ovf", 64'(res_ovf), 64'(hold_ovf));
                chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            end
            if (res_valid && !res_ready) begin
                hold_pend <= 1'b1;
                hold_data <= res_data;
                hold_ovf  <= res_ovf;
            end else begin
                hold_pend <= 1'b0;
            end
            if (res_valid && res_ready) begin
                if (exp_data_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    chk("res_data", 64'(res_data), 64'(exp_data_q.pop_front()));
                    chk("res_ovf", 64'(res_ovf), 64'(exp_ovf_q.pop_front()));
                end
                last_data <= res_data;
                last_ovf  <= res_ovf;
                n_results <= n_results + 1;
            end
        end else begin
            hold_pend <= 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pairs(input int gap, input bit rnd_gap);
        int guard;
        for (int i = 0; i < cur_a.size(); i++) begin
            repeat (rnd_gap ? int'($urandom_range(2, 0)) : gap) tick();
            s_valid = 1'b1;
            s_a     = cur_a[i];
            s_b     = cur_b[i];
            guard   = 0;
            while (!s_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!s_ready) chk("s_ready_timeout", 64'd0, 64'd1);
            tick();
            s_valid = 1'b0;
        end
    endtask

    task automatic start_cmd(input int n);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(n);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_result(input int rdy_dly);
        int guard = 0;
        while (!res_valid && guard < 50) begin
            tick();
            guard++;
        end
        if (!res_valid) chk("res_valid_timeout", 64'd0, 64'd1);
        repeat (rdy_dly) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic do_cmd(input int gap, input bit rnd_gap, input int rdy_dly,
                          output logic [47:0] esum, output logic eovf);
        model(esum, eovf);
        start_cmd(cur_a.size());
        send_pairs(gap, rnd_gap);
        exp_data_q.push_back(esum);
        exp_ovf_q.push_back(eovf);
        n_expected++;
        finish_result(rdy_dly);
    endtask

    task automatic set_pairs(input int n, input int base_a[8], input int base_b[8]);
        cur_a.delete();
        cur_b.delete();
        for (int i = 0; i < n; i++) begin
            cur_a.push_back(18'(base_a[i]));
            cur_b.push_back(18'(base_b[i]));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [47:0] es;
        logic        eo;
        logic [31:0] r;
        int          n;

        // Reset values
        #2;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_dsp_ce", 64'(dsp_ce), 64'd0);
        chk("rst_opmode", 64'(dsp_opmode), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // N=3 back-to-back: 6+20+42
        set_pairs(3, '{2, 4, 6, 0, 0, 0, 0, 0}, '{3, 5, 7, 0, 0, 0, 0, 0});
        do_cmd(0, 1'b0, 0, es, eo);
        chk("t1_model", 64'(es), 64'd68);
        chk("t1_data", 64'(last_data), 64'd68);
        chk("t1_ovf", 64'(last_ovf), 64'd0);

        // N=4 with 2-cycle S_VALID gaps: 1+4+9+16
        set_pairs(4, '{1, 2, 3, 4, 0, 0, 0, 0}, '{1, 2, 3, 4, 0, 0, 0, 0});
        do_cmd(2, 1'b0, 0, es, eo);
        chk("t2_data", 64'(last_data), 64'd30);

        // CMD_LEN=0
        ce_watch = 1'b1;
        ce_seen  = 1'b0;
        exp_data_q.push_back(48'd0);
        exp_ovf_q.push_back(1'b0);
        n_expected++;
        start_cmd(0);
        chk("t3_res_valid_next", 64'(res_valid), 64'd1);
        chk("t3_res_data", 64'(res_data), 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t3_ce_never", 64'(ce_seen), 64'd0);
        ce_watch = 1'b0;

        // N=2 with RES_READY held off 5 cycles
        set_pairs(2, '{10, 1, 0, 0, 0, 0, 0, 0}, '{10, 1, 0, 0, 0, 0, 0, 0});
        do_cmd(0, 1'b0, 5, es, eo);
        chk("t4_data", 64'(last_data), 64'd101);

        // Back-to-back commands, no residue in P
        set_pairs(2, '{100, 1, 0, 0, 0, 0, 0, 0}, '{100, 1, 0, 0, 0, 0, 0, 0});
        do_cmd(0, 1'b0, 0, es, eo);
        chk("t5a_data", 64'(last_data), 64'd10001);
        set_pairs(1, '{3, 0, 0, 0, 0, 0, 0, 0}, '{3, 0, 0, 0, 0, 0, 0, 0});
        do_cmd(0, 1'b0, 0, es, eo);
        chk("t5b_data", 64'(last_data), 64'd9);

        // Reset mid-STREAM of N=5
        set_pairs(2, '{5, 6, 0, 0, 0, 0, 0, 0}, '{5, 6, 0, 0, 0, 0, 0, 0});
        start_cmd(5);
        send_pairs(0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("abort_s_ready", 64'(s_ready), 64'd0);
        chk("abort_dsp_ce", 64'(dsp_ce), 64'd0);
        chk("abort_dsp_a", 64'(dsp_a), 64'd0);
        chk("abort_dsp_b", 64'(dsp_b), 64'd0);
        chk("abort_opmode", 64'(dsp_opmode), 64'd0);
        chk("abort_res_valid", 64'(res_valid), 64'd0);
        chk("abort_ovf", 64'(res_ovf), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        set_pairs(1, '{7, 0, 0, 0, 0, 0, 0, 0}, '{8, 0, 0, 0, 0, 0, 0, 0});
        do_cmd(0, 1'b0, 0, es, eo);
        chk("t6_data", 64'(last_data), 64'd56);

        // Randomized full-range signed operands, gaps and result backpressure
        for (int c = 0; c < 24; c++) begin
            n = int'($urandom_range(8, 1));
            cur_a.delete();
            cur_b.delete();
            for (int i = 0; i < n; i++) begin
                r = $urandom();
                cur_a.push_back(r[17:0]);
                r = $urandom();
                cur_b.push_back(r[17:0]);
            end
            do_cmd(0, 1'b1, int'($urandom_range(3, 0)), es, eo);
        end

        repeat (3) tick();
        chk("result_count", 64'(n_results), 64'(n_expected));
        chk("scoreboard_empty", 64'(exp_data_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dsp_mac_sequencer

`default_nettype wire
